lut_chain_loader: RTL and testbench



---
 rtl/lut_chain_loader.sv | 160 ++++++++++++++++
 tb/tb_lut_chain_loader.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/lut_chain_loader.sv
// Serial configuration loader for a daisy-chained LUT string, with a CRC read-back check.
// Latency: one accept cycle, then CHAIN_LEN load shifts (plus bubbles) and CHAIN_LEN verify shifts.
// Backpressure: in_ready only while the current word finishes and words remain; a late word stalls the chain.
module lut_chain_loader #(
    parameter int CHAIN_LEN = 256,
    parameter int WORD_W    = 8
) (
    input  logic              prog_clk,
    input  logic              prog_rst_n,
    input  logic              cfg_start,
    input  logic              cfg_abort,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              prog_en,
    output logic              prog_in,
    input  logic              prog_out,
    output logic              busy,
    output logic              done,
    output logic              error
);
    localparam int NWORDS = CHAIN_LEN / WORD_W;
    localparam int BCW    = $clog2(CHAIN_LEN + 1);
    localparam int WCW    = $clog2(NWORDS + 1);
    localparam int BIW    = (WORD_W > 1) ? $clog2(WORD_W) : 1;

    localparam logic [BCW-1:0] BIT_LAST  = BCW'(CHAIN_LEN - 1);
    localparam logic [BIW-1:0] BIDX_LAST = BIW'(WORD_W - 1);
    localparam logic [WCW-1:0] WORDS_ALL = WCW'(NWORDS);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_VERIFY = 3'd2,
        S_DONE   = 3'd3,
        S_ERROR  = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic              wv_q, wv_d;
    logic [BIW-1:0]    bidx_q, bidx_d;
    logic [WCW-1:0]    wcnt_q, wcnt_d;
    logic [BCW-1:0]    bcnt_q, bcnt_d;
    logic [15:0]       crc_exp_q, crc_exp_d;
    logic [15:0]       crc_obs_q, crc_obs_d;
    logic              accept;

    // CRC-16-CCITT (poly 0x1021), one bit per call, MSB-first.
    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
        logic fb;
        fb = c[15] ^ b;
        return {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    endfunction

    // State and datapath registers; reset returns to IDLE so prog_en drops asynchronously.
    always_ff @(posedge prog_clk or negedge prog_rst_n) begin
        if (!prog_rst_n) begin
            state_q   <= S_IDLE;
            word_q    <= '0;
            wv_q      <= 1'b0;
            bidx_q    <= '0;
            wcnt_q    <= '0;
            bcnt_q    <= '0;
            crc_exp_q <= '0;
            crc_obs_q <= '0;
        end else begin
            state_q   <= state_d;
            word_q    <= word_d;
            wv_q      <= wv_d;
            bidx_q    <= bidx_d;
            wcnt_q    <= wcnt_d;
            bcnt_q    <= bcnt_d;
            crc_exp_q <= crc_exp_d;
            crc_obs_q <= crc_obs_d;
        end
    end

    // Next-state and outputs; chain outputs depend only on state/registers (and prog_out while recirculating).
    always_comb begin
        state_d   = state_q;
        word_d    = word_q;
        wv_d      = wv_q;
        bidx_d    = bidx_q;
        wcnt_d    = wcnt_q;
        bcnt_d    = bcnt_q;
        crc_exp_d = crc_exp_q;
        crc_obs_d = crc_obs_q;
        accept    = 1'b0;
        in_ready  = 1'b0;
        prog_en   = 1'b0;
        prog_in   = 1'b0;
        busy      = (state_q == S_LOAD) || (state_q == S_VERIFY);
        done      = (state_q == S_DONE);
        error     = (state_q == S_ERROR);

        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (cfg_start) begin
                    state_d   = S_LOAD;
                    wcnt_d    = WORDS_ALL;
                    bcnt_d    = '0;
                    bidx_d    = '0;
                    wv_d      = 1'b0;
                    crc_exp_d = 16'hFFFF;
                    crc_obs_d = 16'hFFFF;
                end
            end
            S_LOAD: begin
                in_ready = (!wv_q || bidx_q == BIDX_LAST) && (wcnt_q != '0);
                prog_en  = wv_q;
                prog_in  = word_q[BIDX_LAST - bidx_q];
                accept   = in_valid && in_ready;
                if (wv_q) begin
                    crc_exp_d = crc_step(crc_exp_q, prog_in);
                    bcnt_d    = bcnt_q + BCW'(1);
                    if (bidx_q == BIDX_LAST) begin
                        wv_d   = 1'b0;
                        bidx_d = '0;
                    end else begin
                        bidx_d = bidx_q + BIW'(1);
                    end
                end
                // A word arriving as the previous one ends keeps shifting gap-free.
                if (accept) begin
                    word_d = in_data;
                    wv_d   = 1'b1;
                    bidx_d = '0;
                    wcnt_d = wcnt_q - WCW'(1);
                end
                if (wv_q && bcnt_q == BIT_LAST) begin
                    state_d = S_VERIFY;
                    bcnt_d  = '0;
                    wv_d    = 1'b0;
                end
            end
            S_VERIFY: begin
                // Recirculate so the chain ends the pass holding what was loaded.
                prog_en   = 1'b1;
                prog_in   = prog_out;
                crc_obs_d = crc_step(crc_obs_q, prog_out);
                bcnt_d    = bcnt_q + BCW'(1);
                if (bcnt_q == BIT_LAST) begin
                    bcnt_d  = '0;
                    state_d = (crc_obs_d == crc_exp_q) ? S_DONE : S_ERROR;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Abort dominates everything, including a simultaneous start.
        if (cfg_abort) begin
            state_d = S_IDLE;
            wv_d    = 1'b0;
            bidx_d  = '0;
            bcnt_d  = '0;
            wcnt_d  = '0;
        end
    end
endmodule

// File: tb/tb_lut_chain_loader.sv
`timescale 1ns/1ps
// Bench for lut_chain_loader: chain model, bit-stream reference and CRC reference.
// Latency: expected timings derived from word count, bubbles and chain length.
// Backpressure: host model inserts idle gaps and offers surplus words after the last one.
module tb_lut_chain_loader;
    localparam int CHAIN_LEN = 256;
    localparam int WORD_W    = 8;
    localparam int NWORDS    = CHAIN_LEN / WORD_W;

    logic        prog_clk   = 1'b0;
    logic        prog_rst_n = 1'b0;
    logic        cfg_start  = 1'b0;
    logic        cfg_abort  = 1'b0;
    logic        in_valid   = 1'b0;
    logic [7:0]  in_data    = 8'h00;
    logic        in_ready, prog_en, prog_in, prog_out, busy, done, error;

    logic [CHAIN_LEN-1:0] chain = '0;
    bit                   stuck_en = 1'b0;
    logic [7:0]           words [NWORDS];

    int n_checks = 0;
    int n_errors = 0;

    int r_load_on, r_load_off, r_ver_on, r_ver_off, r_extra, r_bad_bits, r_edges;
    bit r_timeout;
    bit r_stream[$];
    bit r_readback[$];

    lut_chain_loader #(.CHAIN_LEN(CHAIN_LEN), .WORD_W(WORD_W)) dut (
        .prog_clk  (prog_clk),
        .prog_rst_n(prog_rst_n),
        .cfg_start (cfg_start),
        .cfg_abort (cfg_abort),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .prog_en   (prog_en),
        .prog_in   (prog_in),
        .prog_out  (prog_out),
        .busy      (busy),
        .done      (done),
        .error     (error)
    );

    always #5 prog_clk = ~prog_clk;

    // LUT chain: bits enter at position 0, the far end drives prog_out.
    assign prog_out = chain[CHAIN_LEN-1];
    always @(posedge prog_clk) begin
        if (prog_en) chain <= {chain[CHAIN_LEN-2:0], prog_in};
        if (stuck_en) chain[100] <= 1'b0;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] crc_of(input bit q[$]);
        logic [15:0] c;
        c = 16'hFFFF;
        foreach (q[i]) c = {c[14:0], 1'b0} ^ ((c[15] ^ q[i]) ? 16'h1021 : 16'h0000);
        return c;
    endfunction

    task automatic fill_random();
        for (int w = 0; w < NWORDS; w++) words[w] = 8'($urandom);
    endtask

    task automatic fill_ramp();
        for (int w = 0; w < NWORDS; w++) words[w] = 8'(w);
    endtask

    // One configuration pass driven by a host model; g3/g17 are idle-while-ready gaps after words 3 and 17.
    task automatic do_run(input int g3, input int g17, input int abort_bit, input int start_at_ver,
                          input int rst_at_ver, input bit use_stuck);
        int idx = 0;
        int gap_left = 0;
        int shifted = 0;
        int cyc = 0;
        bit pe, pi, po, rdy;
        r_stream = {};
        r_readback = {};
        for (int w = 0; w < NWORDS; w++)
            for (int b = WORD_W - 1; b >= 0; b--) r_stream.push_back(words[w][b]);
        r_load_on = 0; r_load_off = 0; r_ver_on = 0; r_ver_off = 0;
        r_extra = 0; r_bad_bits = 0; r_edges = 0; r_timeout = 1'b0;

        @(negedge prog_clk); cfg_start = 1'b1;
        @(negedge prog_clk); cfg_start = 1'b0;
        chk("start_state", {29'd0, busy, done, error}, 32'b100);
        while (1) begin
            cyc++;
            if (!busy) begin r_edges = cyc - 1; break; end
            if (cyc > 2000) begin r_timeout = 1'b1; break; end
            if (use_stuck && shifted >= CHAIN_LEN) stuck_en = 1'b1;
            pe = prog_en; pi = prog_in; po = prog_out; rdy = in_ready;
            in_valid  = (gap_left == 0);
            in_data   = (idx < NWORDS) ? words[idx] : 8'hA5;
            cfg_start = (start_at_ver >= 0 && shifted >= CHAIN_LEN && r_ver_on == start_at_ver);
            cfg_abort = (abort_bit >= 0 && pe && shifted == abort_bit);
            if (pe) begin
                if (shifted < CHAIN_LEN) begin
                    if (pi !== r_stream[shifted]) r_bad_bits++;
                    r_load_on++;
                    shifted++;
                end else begin
                    if (pi !== po) r_bad_bits++;
                    r_readback.push_back(po);
                    r_ver_on++;
                end
            end else if (shifted < CHAIN_LEN) begin
                if (idx > 0) r_load_off++;
            end else begin
                r_ver_off++;
            end
            if (in_valid && rdy) begin
                if (idx >= NWORDS) r_extra++;
                else begin
                    idx++;
                    if (idx == 4)  gap_left = g3;
                    if (idx == 18) gap_left = g17;
                end
            end else if (!in_valid && rdy && gap_left > 0) begin
                gap_left--;
            end
            if (cfg_abort) begin
                @(negedge prog_clk);
                cfg_abort = 1'b0; in_valid = 1'b0;
                chk("abort_busy", {31'd0, busy}, 0);
                chk("abort_prog_en", {31'd0, prog_en}, 0);
                chk("abort_in_ready", {31'd0, in_ready}, 0);
                chk("abort_done_error", {30'd0, done, error}, 0);
                return;
            end
            if (rst_at_ver >= 0 && shifted >= CHAIN_LEN && r_ver_on == rst_at_ver) begin
                @(posedge prog_clk); #3;
                chk("pre_rst_prog_en", {31'd0, prog_en}, 1);
                prog_rst_n = 1'b0;
                #1;
                chk("rst_prog_en", {31'd0, prog_en}, 0);
                chk("rst_busy_done_error", {29'd0, busy, done, error}, 0);
                @(negedge prog_clk);
                in_valid = 1'b0; cfg_start = 1'b0;
                prog_rst_n = 1'b1;
                return;
            end
            @(negedge prog_clk);
        end
        in_valid = 1'b0; cfg_start = 1'b0; cfg_abort = 1'b0; stuck_en = 1'b0;
    endtask

    // Checks after a pass on a healthy chain that must end verified.
    task automatic check_good(input int gaps);
        int mism = 0;
        bit ok;
        for (int i = 0; i < CHAIN_LEN; i++)
            if (chain[CHAIN_LEN-1-i] !== r_stream[i]) mism++;
        ok = (crc_of(r_readback) == crc_of(r_stream));
        chk("timeout", {31'd0, r_timeout}, 0);
        chk("edges_to_done", r_edges, 513 + gaps);
        chk("load_prog_en_high", r_load_on, CHAIN_LEN);
        chk("load_bubbles", r_load_off, gaps);
        chk("verify_prog_en_high", r_ver_on, CHAIN_LEN);
        chk("verify_prog_en_low", r_ver_off, 0);
        chk("surplus_words_taken", r_extra, 0);
        chk("prog_in_bits", r_bad_bits, 0);
        chk("chain_contents", mism, 0);
        chk("readback_crc_ok", {31'd0, ok}, 1);
        chk("result", {29'd0, busy, done, error}, {29'd0, 1'b0, ok, !ok});
    endtask

    initial begin
        #2;
        chk("reset_outputs", {26'd0, in_ready, prog_en, prog_in, busy, done, error}, 0);
        @(negedge prog_clk); prog_rst_n = 1'b1;
        repeat (2) @(negedge prog_clk);
        chk("idle_outputs", {26'd0, in_ready, prog_en, prog_in, busy, done, error}, 0);

        // Start and abort together while idle: abort wins.
        cfg_start = 1'b1; cfg_abort = 1'b1;
        @(negedge prog_clk); cfg_start = 1'b0; cfg_abort = 1'b0;
        chk("start_abort_idle", {29'd0, busy, in_ready, prog_en}, 0);

        // Ramp stream, no gaps.
        fill_ramp();
        do_run(0, 0, -1, -1, -1, 1'b0);
        check_good(0);
        chk("lut0_addr0", {31'd0, chain[0]}, {31'd0, words[NWORDS-1][0]});
        repeat (3) @(negedge prog_clk);
        chk("done_sticky", {30'd0, done, error}, 32'b10);

        // Ramp stream with two 5-cycle gaps.
        do_run(5, 5, -1, -1, -1, 1'b0);
        check_good(10);

        // Stuck-at-0 at chain position 100 during read-back.
        do_run(0, 0, -1, -1, -1, 1'b1);
        chk("stuck_timeout", {31'd0, r_timeout}, 0);
        chk("stuck_readback_differs", {31'd0, crc_of(r_readback) != crc_of(r_stream)}, 1);
        chk("stuck_result", {29'd0, busy, done, error}, 32'b001);

        // Abort at load bit 77, then a fresh complete load.
        fill_random();
        do_run(0, 0, 77, -1, -1, 1'b0);
        fill_random();
        do_run(0, 0, -1, -1, -1, 1'b0);
        check_good(0);

        // Random gaps and a start pulse during read-back.
        begin
            int ga, gb;
            ga = int'($urandom_range(1, 6));
            gb = int'($urandom_range(1, 6));
            fill_random();
            do_run(ga, gb, -1, 100, -1, 1'b0);
            check_good(ga + gb);
        end

        // Asynchronous reset in the middle of read-back, then recovery.
        fill_random();
        do_run(0, 0, -1, -1, 50, 1'b0);
        repeat (2) @(negedge prog_clk);
        chk("post_rst_idle", {26'd0, in_ready, prog_en, prog_in, busy, done, error}, 0);
        fill_random();
        do_run(0, 0, -1, -1, -1, 1'b0);
        check_good(0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
